// File: rtl/pipe_pkg.sv
// Shared definitions for the inter-stage pipeline registers: per-stage
// bundle widths, control-bit positions and the skid-buffer state encoding.
package pipe_pkg;

   // Per-stage bundle widths
   localparam int IF_ID_CTRL_W  = 4;
   localparam int IF_ID_DATA_W  = 64;
   localparam int ID_EX_CTRL_W  = 8;
   localparam int ID_EX_DATA_W  = 64;
   localparam int EX_MEM_CTRL_W = 8;
   localparam int EX_MEM_DATA_W = 64;
   localparam int MEM_WB_CTRL_W = 8;
   localparam int MEM_WB_DATA_W = 64;

   // Control-bit positions inside the ctrl bundle
   localparam int REGWRITE_BIT  = 0;
   localparam int MEM_READ_BIT  = 1;
   localparam int MEM_WRITE_BIT = 2;
   localparam int WB_SEL_LSB    = 3;
   localparam int WB_SEL_MSB    = 4;

   // Skid-buffer fill state
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } skid_state_t;

   // Number of valid entries among head and skid
   function automatic logic [1:0] count_valid(input logic a, input logic b);
      return {1'b0, a} + {1'b0, b};
   endfunction

endpackage

// File: rtl/pipe_entry_reg.sv
// One pipeline entry: valid bit, control bundle and data bundle.
// clear wins over load. Control is always cleared; data only when DATA_RST=1,
// otherwise data keeps its last value so it needs no reset net.
module pipe_entry_reg #(
   parameter int CTRL_W   = 8,
   parameter int DATA_W   = 64,
   parameter bit DATA_RST = 1'b0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load,
   input  logic              clear,
   input  logic [CTRL_W-1:0] next_ctrl,
   input  logic [DATA_W-1:0] next_data,
   output logic              valid,
   output logic [CTRL_W-1:0] ctrl,
   output logic [DATA_W-1:0] data
);

   // Valid and control: async reset, clear has priority over load
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid <= 1'b0;
         ctrl  <= '0;
      end else if (clear) begin
         valid <= 1'b0;
         ctrl  <= '0;
      end else if (load) begin
         valid <= 1'b1;
         ctrl  <= next_ctrl;
      end
   end

   generate
      if (DATA_RST) begin : g_data_rst
         // Data cleared by reset and clear
         always_ff @(posedge clk or negedge reset) begin
            if (!reset)      data <= '0;
            else if (clear)  data <= '0;
            else if (load)   data <= next_data;
         end
      end else begin : g_data_hold
         // Data only ever loaded; a cleared entry keeps its stale data
         always_ff @(posedge clk) begin
            if (load && !clear) data <= next_data;
         end
      end
   endgenerate

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake, flush and an
// optional 2-entry skid buffer.
//
// Handshake: an entry moves on a rising edge where valid and ready are both 1
// (accept = in_valid & in_ready, issue = out_valid & out_ready). valid never
// depends on ready; once raised, out_valid and the head stay stable until issue.
// Flush kills held entries and the current input, but an issue in the same
// cycle still completes because downstream sampled the head before the edge.
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int CTRL_W   = 8,
   parameter int DATA_W   = 64,
   parameter bit SKID     = 1'b1,
   parameter bit DATA_RST = 1'b0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        occupancy
);

   logic              started;
   logic              accept;
   logic              issue;
   logic              head_valid;
   logic [CTRL_W-1:0] head_ctrl;
   logic [DATA_W-1:0] head_data;
   logic              head_load;
   logic              head_clear;
   logic [CTRL_W-1:0] head_next_ctrl;
   logic [DATA_W-1:0] head_next_data;

   // in_ready stays low during reset and rises on the first edge after release
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) started <= 1'b0;
      else        started <= 1'b1;
   end

   assign accept = in_valid & in_ready;
   assign issue  = head_valid & out_ready;

   pipe_entry_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .DATA_RST(DATA_RST)) u_head (
      .clk       (clk),
      .reset     (reset),
      .load      (head_load),
      .clear     (head_clear),
      .next_ctrl (head_next_ctrl),
      .next_data (head_next_data),
      .valid     (head_valid),
      .ctrl      (head_ctrl),
      .data      (head_data)
   );

   assign out_valid = head_valid;
   assign out_ctrl  = head_ctrl & {CTRL_W{head_valid}};
   assign out_data  = head_data;

   generate
      if (SKID) begin : g_skid
         skid_state_t       state;
         logic              skid_valid;
         logic [CTRL_W-1:0] skid_ctrl;
         logic [DATA_W-1:0] skid_data;
         logic              skid_load;
         logic              skid_clear;

         // Entry load/clear decode; head refills from skid when draining TWO
         always_comb begin
            head_load      = 1'b0;
            head_clear     = flush;
            skid_load      = 1'b0;
            skid_clear     = flush;
            head_next_ctrl = in_ctrl;
            head_next_data = in_data;
            case (state)
               ST_EMPTY: head_load = accept;
               ST_ONE: begin
                  head_load  = accept & issue;
                  skid_load  = accept & ~issue;
                  head_clear = flush | (issue & ~accept);
               end
               ST_TWO: begin
                  head_load      = issue;
                  skid_clear     = flush | issue;
                  head_next_ctrl = skid_ctrl;
                  head_next_data = skid_data;
               end
               default: head_clear = 1'b1;
            endcase
         end

         // Fill-level state machine; flush always returns to EMPTY
         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               state <= ST_EMPTY;
            end else if (flush) begin
               state <= ST_EMPTY;
            end else begin
               case (state)
                  ST_EMPTY: if (accept) state <= ST_ONE;
                  ST_ONE: begin
                     if (accept && !issue)      state <= ST_TWO;
                     else if (!accept && issue) state <= ST_EMPTY;
                  end
                  ST_TWO:   if (issue) state <= ST_ONE;
                  default:  state <= ST_EMPTY;
               endcase
            end
         end

         pipe_entry_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .DATA_RST(DATA_RST)) u_skid (
            .clk       (clk),
            .reset     (reset),
            .load      (skid_load),
            .clear     (skid_clear),
            .next_ctrl (in_ctrl),
            .next_data (in_data),
            .valid     (skid_valid),
            .ctrl      (skid_ctrl),
            .data      (skid_data)
         );

         assign in_ready  = started & (state != ST_TWO);
         assign occupancy = count_valid(head_valid, skid_valid);
      end else begin : g_single
         // Single entry: refill on accept, empty on issue without refill
         always_comb begin
            head_load      = accept;
            head_clear     = flush | (issue & ~accept);
            head_next_ctrl = in_ctrl;
            head_next_data = in_data;
         end

         assign in_ready  = started & (~head_valid | out_ready);
         assign occupancy = {1'b0, head_valid};
      end
   endgenerate

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a SKID=1/DATA_RST=0 instance and a SKID=0/DATA_RST=1
// instance. Each has a queue model of held entries that predicts in_ready,
// out_valid, occupancy and the next head.
module tb_pipe_stage_reg;

   localparam int CW = 8;
   localparam int DW = 64;
   localparam int EW = CW + DW;

   logic          clk;
   logic          reset;
   logic          flush1, iv1, or1, in_ready1, out_valid1;
   logic [CW-1:0] ic1, out_ctrl1;
   logic [DW-1:0] id1, out_data1;
   logic [1:0]    occ1;
   logic          flush0, iv0, or0, in_ready0, out_valid0;
   logic [CW-1:0] ic0, out_ctrl0;
   logic [DW-1:0] id0, out_data0;
   logic [1:0]    occ0;

   logic [EW-1:0] exp_q1[$];
   logic [EW-1:0] exp_q0[$];
   int            n_checks = 0;
   int            n_fail   = 0;
   int            n_d_cap  = 0;
   logic          mon_en   = 1'b0;
   logic          started;

   pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1'b1), .DATA_RST(1'b0)) dut1 (
      .clk(clk), .reset(reset), .flush(flush1), .in_valid(iv1), .in_ready(in_ready1),
      .in_ctrl(ic1), .in_data(id1), .out_valid(out_valid1), .out_ready(or1),
      .out_ctrl(out_ctrl1), .out_data(out_data1), .occupancy(occ1)
   );

   pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1'b0), .DATA_RST(1'b1)) dut0 (
      .clk(clk), .reset(reset), .flush(flush0), .in_valid(iv0), .in_ready(in_ready0),
      .in_ctrl(ic0), .in_data(id0), .out_valid(out_valid0), .out_ready(or0),
      .out_ctrl(out_ctrl0), .out_data(out_data0), .occupancy(occ0)
   );

   // Clock and reset-release tracking
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk or negedge reset) begin
      if (!reset) started <= 1'b0;
      else        started <= 1'b1;
   end

   task automatic check_eq(input string tag, input logic [EW-1:0] got, input logic [EW-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive1(input logic v, input logic [DW-1:0] d, input logic rdy, input logic fl);
      iv1 = v; ic1 = 8'h01; id1 = d; or1 = rdy; flush1 = fl;
   endtask

   // Scoreboard for the skid instance: decide this cycle's accept/issue from the model
   always @(negedge clk) begin
      logic          m_rdy;
      logic [EW-1:0] e;
      if (mon_en && reset) begin
         m_rdy = started && (exp_q1.size() < 2);
         check_eq("rdy1", EW'(in_ready1), EW'(m_rdy));
         check_eq("val1", EW'(out_valid1), EW'(exp_q1.size() != 0));
         check_eq("occ1", EW'(occ1), EW'(exp_q1.size()));
         if (!out_valid1) check_eq("bubble1", EW'(out_ctrl1), '0);
         if (exp_q1.size() != 0 && or1) begin
            e = exp_q1.pop_front();
            check_eq("head1", {out_ctrl1, out_data1}, e);
            if (out_valid1 && out_data1 == 64'h0D) n_d_cap++;
         end
         if (flush1)             exp_q1.delete();
         else if (iv1 && m_rdy)  exp_q1.push_back({ic1, id1});
      end
   end

   // Scoreboard for the single-entry instance
   always @(negedge clk) begin
      logic          m_rdy;
      logic [EW-1:0] e;
      if (mon_en && reset) begin
         m_rdy = started && (exp_q0.size() == 0 || or0);
         check_eq("rdy0", EW'(in_ready0), EW'(m_rdy));
         check_eq("val0", EW'(out_valid0), EW'(exp_q0.size() != 0));
         check_eq("occ0", EW'(occ0), EW'(exp_q0.size()));
         if (!out_valid0) check_eq("bubble0", EW'(out_ctrl0), '0);
         if (exp_q0.size() != 0 && or0) begin
            e = exp_q0.pop_front();
            check_eq("head0", {out_ctrl0, out_data0}, e);
         end
         if (flush0)             exp_q0.delete();
         else if (iv0 && m_rdy)  exp_q0.push_back({ic0, id0});
      end
   end

   initial begin
      reset = 1'b0;
      drive1(1'b0, '0, 1'b0, 1'b0);
      iv0 = 1'b0; ic0 = '0; id0 = '0; or0 = 1'b0; flush0 = 1'b0;

      // Reset values
      #2;
      check_eq("rst_val1", EW'(out_valid1), '0);
      check_eq("rst_ctrl1", EW'(out_ctrl1), '0);
      check_eq("rst_occ1", EW'(occ1), '0);
      check_eq("rst_rdy1", EW'(in_ready1), '0);
      check_eq("rst_rdy0", EW'(in_ready0), '0);
      check_eq("rst_data0", EW'(out_data0), '0);
      repeat (2) @(posedge clk);
      #2 reset = 1'b1;
      check_eq("rdy_before_edge", EW'(in_ready1), '0);
      step();
      check_eq("rdy_after_rel1", EW'(in_ready1), EW'(1));
      check_eq("rdy_after_rel0", EW'(in_ready0), EW'(1));
      mon_en = 1'b1;

      // Streaming with no back-pressure
      for (int i = 1; i <= 8; i++) begin
         drive1(1'b1, DW'(i), 1'b1, 1'b0);
         step();
      end
      drive1(1'b0, '0, 1'b1, 1'b0);
      repeat (2) step();

      // Back-pressure: A and B held, then drained in order
      drive1(1'b1, 64'h0A, 1'b0, 1'b0); step();
      drive1(1'b1, 64'h0B, 1'b0, 1'b0); step();
      drive1(1'b0, '0, 1'b0, 1'b0);
      repeat (3) step();
      check_eq("bp_occ", EW'(occ1), EW'(2));
      check_eq("bp_rdy", EW'(in_ready1), '0);
      check_eq("bp_head", EW'(out_data1), EW'(64'h0A));
      drive1(1'b0, '0, 1'b1, 1'b0);
      repeat (3) step();

      // Flush while full, with a new entry offered
      drive1(1'b1, 64'h0A, 1'b0, 1'b0); step();
      drive1(1'b1, 64'h0B, 1'b0, 1'b0); step();
      drive1(1'b1, 64'h0C, 1'b0, 1'b1); step();
      drive1(1'b0, '0, 1'b1, 1'b0);
      check_eq("fl2_val", EW'(out_valid1), '0);
      check_eq("fl2_ctrl", EW'(out_ctrl1), '0);
      check_eq("fl2_occ", EW'(occ1), '0);
      repeat (3) step();

      // Flush in ONE with a simultaneous accept: the accept is dropped
      drive1(1'b1, 64'h0A, 1'b0, 1'b0); step();
      drive1(1'b1, 64'h0E, 1'b0, 1'b1); step();
      drive1(1'b0, '0, 1'b1, 1'b0);
      check_eq("fl1_occ", EW'(occ1), '0);
      repeat (2) step();

      // Flush and issue together: head 0x0D captured exactly once
      drive1(1'b1, 64'h0D, 1'b0, 1'b0); step();
      n_d_cap = 0;
      drive1(1'b0, '0, 1'b1, 1'b1); step();
      drive1(1'b0, '0, 1'b1, 1'b0);
      repeat (2) step();
      check_eq("fl_iss_cap", EW'(n_d_cap), EW'(1));
      check_eq("fl_iss_occ", EW'(occ1), '0);

      // Single entry: in_ready follows out_ready combinationally when full
      iv0 = 1'b1; ic0 = 8'h02; id0 = 64'h21; or0 = 1'b0; step();
      id0 = 64'h22; #1;
      check_eq("s0_rdy_lo", EW'(in_ready0), '0);
      or0 = 1'b1; #1;
      check_eq("s0_rdy_hi", EW'(in_ready0), EW'(1));
      step();
      id0 = 64'h23; or0 = 1'b0; #1;
      check_eq("s0_rdy_lo2", EW'(in_ready0), '0);
      step();
      or0 = 1'b1; #1;
      check_eq("s0_rdy_hi2", EW'(in_ready0), EW'(1));
      step();
      iv0 = 1'b0; repeat (2) step();

      // Random traffic on both instances
      for (int i = 0; i < 400; i++) begin
         iv1 = 1'($urandom_range(0, 1)); ic1 = 8'($urandom); id1 = {$urandom, $urandom};
         or1 = 1'($urandom_range(0, 1)); flush1 = ($urandom_range(0, 15) == 0);
         iv0 = 1'($urandom_range(0, 1)); ic0 = 8'($urandom); id0 = {$urandom, $urandom};
         or0 = 1'($urandom_range(0, 1)); flush0 = ($urandom_range(0, 15) == 0);
         step();
      end
      drive1(1'b0, '0, 1'b1, 1'b0);
      iv0 = 1'b0; or0 = 1'b1; flush0 = 1'b0;
      repeat (3) step();

      // Asynchronous reset mid-stream with entries held
      drive1(1'b1, 64'h55, 1'b0, 1'b0);
      iv0 = 1'b1; id0 = 64'h66; or0 = 1'b0;
      step();
      drive1(1'b0, '0, 1'b0, 1'b0);
      iv0 = 1'b0;
      step();
      #1;
      mon_en = 1'b0;
      reset = 1'b0;
      #1;
      check_eq("arst_val1", EW'(out_valid1), '0);
      check_eq("arst_ctrl1", EW'(out_ctrl1), '0);
      check_eq("arst_occ1", EW'(occ1), '0);
      check_eq("arst_val0", EW'(out_valid0), '0);
      check_eq("arst_data0", EW'(out_data0), '0);
      exp_q1.delete();
      exp_q0.delete();
      @(posedge clk);
      #2 reset = 1'b1;
      step();
      check_eq("arst_rdy1", EW'(in_ready1), EW'(1));
      mon_en = 1'b1;

      // Recovery stream after reset
      for (int i = 0; i < 4; i++) begin
         drive1(1'b1, DW'(64'h100 + i), 1'b1, 1'b0);
         iv0 = 1'b1; id0 = DW'(64'h200 + i); or0 = 1'b1;
         step();
      end
      drive1(1'b0, '0, 1'b1, 1'b0);
      iv0 = 1'b0;
      repeat (3) step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
